// File: rtl/byte_to_burst_pkg.sv
// Shared DDR definitions: burst size encoding, read FSM states, beat math.
package byte_to_burst_pkg;

  typedef enum logic [1:0] {
    BURST_1B = 2'd0,
    BURST_2B = 2'd1,
    BURST_4B = 2'd2,
    BURST_8B = 2'd3
  } burst_size_t;

  typedef enum logic {
    RD_IDLE    = 1'b0,
    RD_COLLECT = 1'b1
  } rd_state_t;

  localparam int MAX_BURST_NUM = 15;

  // Number of DDR beats (rise+fall pairs) that make up one word.
  function automatic logic [2:0] beats_for_size(burst_size_t sz);
    case (sz)
      BURST_4B: return 3'd2;
      BURST_8B: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/byte_to_burst_if.sv
// Read-path bus between DQ capture, the read FSM and the pool read side.
interface byte_to_burst_if;
  logic        start;
  logic [1:0]  burst_size;
  logic [3:0]  burst_num;
  logic        dqs_valid;
  logic [7:0]  dq_rise;
  logic [7:0]  dq_fall;
  logic [63:0] pool_rdata;
  logic        rdata_valid;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport master (
    output start, burst_size, burst_num, dqs_valid, dq_rise, dq_fall,
    input  pool_rdata, rdata_valid, busy, done, timeout_err
  );

  modport slave (
    input  start, burst_size, burst_num, dqs_valid, dq_rise, dq_fall,
    output pool_rdata, rdata_valid, busy, done, timeout_err
  );
endinterface

// File: rtl/byte_to_burst_rx_word_assembler.sv
// Beat-indexed byte-lane register. word_o is the stored lanes merged with
// the beat currently presented, so the caller can capture a complete word
// on the same edge that samples the final beat.
module rx_word_assembler
  import byte_to_burst_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        beat_en,
  input  logic        beat_last,
  input  logic [1:0]  beat_idx,
  input  burst_size_t size,
  input  logic [7:0]  dq_rise,
  input  logic [7:0]  dq_fall,
  output logic [63:0] word_o
);

  logic [63:0] lanes_q, lanes_d;
  logic [63:0] merged;
  logic [5:0]  lo_bit;

  // Drop the current beat's bytes into lanes 2k / 2k+1; single-byte words
  // ignore the falling-edge byte.
  always_comb begin
    lo_bit = {beat_idx, 4'b0000};
    merged = lanes_q;
    merged[lo_bit +: 8]        = dq_rise;
    merged[lo_bit + 6'd8 +: 8] = (size == BURST_1B) ? 8'h00 : dq_fall;
  end

  assign word_o = merged;

  // Lanes restart from zero after each completed word so upper bytes read 0.
  always_comb begin
    lanes_d = lanes_q;
    if (clr || (beat_en && beat_last)) lanes_d = '0;
    else if (beat_en)                  lanes_d = merged;
  end

  // Lane storage register.
  always_ff @(posedge clk) begin
    if (rst) lanes_q <= '0;
    else     lanes_q <= lanes_d;
  end

endmodule

// File: rtl/byte_to_burst.sv
// byte_to_burst: reassembles DDR read beats into 64-bit pool words.
// Optional idle-strobe abort is built when BYTE_TO_BURST_TIMEOUT_EN is defined.
module byte_to_burst
  import byte_to_burst_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  byte_to_burst_if.slave  bus
);

  rd_state_t   state_q, state_d;
  burst_size_t size_q, size_d;
  logic [3:0]  num_q, num_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic [63:0] pool_rdata_q, pool_rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        done_q, done_d;
  logic        asm_clr, beat_en, beat_last;
  logic [63:0] asm_word;
`ifdef BYTE_TO_BURST_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          tmo_q, tmo_d;
`endif

  rx_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .beat_en   (beat_en),
    .beat_last (beat_last),
    .beat_idx  (beat_cnt_q),
    .size      (size_q),
    .dq_rise   (bus.dq_rise),
    .dq_fall   (bus.dq_fall),
    .word_o    (asm_word)
  );

  // Read FSM: latch transaction on start, consume beats, emit words.
  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    num_d         = num_q;
    beat_cnt_d    = beat_cnt_q;
    word_cnt_d    = word_cnt_q;
    pool_rdata_d  = pool_rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    asm_clr       = 1'b0;
    beat_en       = 1'b0;
    beat_last     = 1'b0;
`ifdef BYTE_TO_BURST_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
    tmo_d         = 1'b0;
`endif
    case (state_q)
      RD_IDLE: begin
        if (bus.start) begin
          size_d     = burst_size_t'(bus.burst_size);
          num_d      = (bus.burst_num == 4'd0) ? 4'd1 : bus.burst_num;
          beat_cnt_d = '0;
          word_cnt_d = '0;
          asm_clr    = 1'b1;
          state_d    = RD_COLLECT;
`ifdef BYTE_TO_BURST_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
      end
      RD_COLLECT: begin
        if (bus.dqs_valid) begin
          beat_en = 1'b1;
`ifdef BYTE_TO_BURST_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if ({1'b0, beat_cnt_q} == beats_for_size(size_q) - 3'd1) begin
            beat_last     = 1'b1;
            pool_rdata_d  = asm_word;
            rdata_valid_d = 1'b1;
            beat_cnt_d    = '0;
            word_cnt_d    = word_cnt_q + 4'd1;
            if (word_cnt_q == num_q - 4'd1) begin
              done_d  = 1'b1;
              state_d = RD_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end
`ifdef BYTE_TO_BURST_TIMEOUT_EN
        else if (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          asm_clr = 1'b1;
          state_d = RD_IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RD_IDLE;
      size_q        <= BURST_1B;
      num_q         <= 4'd1;
      beat_cnt_q    <= '0;
      word_cnt_q    <= '0;
      pool_rdata_q  <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      num_q         <= num_d;
      beat_cnt_q    <= beat_cnt_d;
      word_cnt_q    <= word_cnt_d;
      pool_rdata_q  <= pool_rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

`ifdef BYTE_TO_BURST_TIMEOUT_EN
  // Idle-strobe counter and abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      tmo_q      <= tmo_d;
    end
  end
  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.pool_rdata  = pool_rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q == RD_COLLECT);

endmodule

// File: tb/tb_byte_to_burst.sv
// Directed bench for byte_to_burst: table of per-cycle vectors plus
// hand sequences for reset mid-burst and idle-strobe behaviour.
module tb_byte_to_burst;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_to_burst_if bus();

  byte_to_burst #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic [3:0]  nm;
    logic        dv;
    logic [7:0]  r;
    logic [7:0]  f;
    logic        e_v;
    logic [63:0] e_d;
    logic        e_b;
    logic        e_dn;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [1:0] sz, input logic [3:0] nm,
                     input logic dv, input logic [7:0] r, input logic [7:0] f,
                     input logic ev, input logic [63:0] ed, input logic eb, input logic edn);
    vec_t v;
    v.st = st; v.sz = sz; v.nm = nm; v.dv = dv; v.r = r; v.f = f;
    v.e_v = ev; v.e_d = ed; v.e_b = eb; v.e_dn = edn;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [1:0] sz, input logic [3:0] nm,
                       input logic dv, input logic [7:0] r, input logic [7:0] f);
    bus.start = st; bus.burst_size = sz; bus.burst_num = nm;
    bus.dqs_valid = dv; bus.dq_rise = r; bus.dq_fall = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] d,
                         input logic b, input logic dn, input logic te);
    chk({tag, ".rdata_valid"}, {63'd0, bus.rdata_valid}, {63'd0, v});
    chk({tag, ".pool_rdata"},  bus.pool_rdata, d);
    chk({tag, ".busy"},        {63'd0, bus.busy}, {63'd0, b});
    chk({tag, ".done"},        {63'd0, bus.done}, {63'd0, dn});
    chk({tag, ".timeout_err"}, {63'd0, bus.timeout_err}, {63'd0, te});
  endtask

  initial begin
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    rst = 1'b1;
    tick(); tick();
    chk_out("reset", 0, 64'h0, 0, 0, 0);
    rst = 1'b0;

    //  st sz nm dv  rise   fall   | v  data                   busy done
    add(0, 0, 0, 1, 8'haa, 8'hbb,    0, 64'h0,                 0, 0); // strobe in idle ignored
    add(1, 3, 1, 1, 8'h11, 8'h22,    0, 64'h0,                 1, 0); // beat in start cycle ignored
    add(0, 0, 0, 1, 8'h6b, 8'h07,    0, 64'h0,                 1, 0);
    add(0, 0, 0, 1, 8'h89, 8'hde,    0, 64'h0,                 1, 0);
    add(0, 0, 0, 1, 8'ha4, 8'h74,    0, 64'h0,                 1, 0);
    add(0, 0, 0, 1, 8'ha8, 8'h44,    1, 64'h44a874a4de89076b,  0, 1);
    add(1, 0, 2, 0, 8'h00, 8'h00,    0, 64'h44a874a4de89076b,  1, 0); // start on done cycle
    add(0, 0, 0, 1, 8'h30, 8'hff,    1, 64'h30,                1, 0);
    add(0, 0, 0, 1, 8'h3a, 8'hff,    1, 64'h3a,                0, 1);
    add(1, 2, 1, 0, 8'h00, 8'h00,    0, 64'h3a,                1, 0);
    add(0, 0, 0, 1, 8'h5d, 8'h1e,    0, 64'h3a,                1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00,    0, 64'h3a,                1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00,    0, 64'h3a,                1, 0);
    add(0, 0, 0, 1, 8'ha0, 8'h0a,    1, 64'h0aa01e5d,          0, 1);
    add(1, 1, 0, 0, 8'h00, 8'h00,    0, 64'h0aa01e5d,          1, 0); // num 0 -> 1
    add(1, 3, 5, 1, 8'h34, 8'h12,    1, 64'h1234,              0, 1); // start while busy ignored
    add(0, 0, 0, 1, 8'h55, 8'h66,    0, 64'h1234,              0, 0);
    add(1, 1, 2, 0, 8'h00, 8'h00,    0, 64'h1234,              1, 0);
    add(0, 0, 0, 1, 8'h01, 8'h02,    1, 64'h0201,              1, 0);
    add(0, 0, 0, 1, 8'h03, 8'h04,    1, 64'h0403,              0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sz, tbl[i].nm, tbl[i].dv, tbl[i].r, tbl[i].f);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_d, tbl[i].e_b, tbl[i].e_dn, 1'b0);
    end

    // Reset mid-burst: two of four beats, then reset with a beat present.
    drive(1, 3, 2, 0, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 1, 8'hc1, 8'hc2); tick();
    chk("mid.valid0", {63'd0, bus.rdata_valid}, 64'd0);
    drive(0, 0, 0, 1, 8'hc3, 8'hc4); tick();
    chk("mid.valid1", {63'd0, bus.rdata_valid}, 64'd0);
    rst = 1'b1;
    drive(0, 0, 0, 1, 8'hc5, 8'hc6); tick();
    chk_out("midrst", 0, 64'h0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 8'hc7, 8'hc8); tick();
    chk_out("postrst", 0, 64'h0, 0, 0, 0);
    drive(1, 2, 1, 0, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 1, 8'h11, 8'h22); tick();
    chk("fresh.valid0", {63'd0, bus.rdata_valid}, 64'd0);
    drive(0, 0, 0, 1, 8'h33, 8'h44); tick();
    chk_out("fresh", 1, 64'h44332211, 0, 1, 0);

    // Idle strobe after one word of three.
    drive(1, 1, 3, 0, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 1, 8'haa, 8'h55); tick();
    chk_out("tmo.word", 1, 64'h55aa, 1, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk_out($sformatf("idle%0d", i), 0, 64'h55aa, 1, 0, 0);
    end
    tick();
`ifdef BYTE_TO_BURST_TIMEOUT_EN
    chk_out("tmo.abort", 0, 64'h55aa, 0, 0, 1);
    tick();
    chk_out("tmo.after", 0, 64'h55aa, 0, 0, 0);
`else
    chk_out("idle15", 0, 64'h55aa, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk_out("idle.long", 0, 64'h55aa, 1, 0, 0);
    drive(0, 0, 0, 1, 8'h0b, 8'h0c); tick();
    chk_out("late.word", 1, 64'h0c0b, 1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_to_burst.md
# byte_to_burst

Read-path counterpart of the write serializer: collects DDR read-data beats (rising- and falling-edge bytes, already captured per `clk` by the PHY) and reassembles them into 64-bit words for the data pool. It sits between the DQ capture logic and the read side of the pool. It supports the same burst sizes as the write path (1, 2, 4 or 8 bytes per word) and up to 15 words per read transaction.

## Interface
- `TIMEOUT_CYCLES`, 16: idle-strobe cycles before abort (used only when the timeout feature is compiled in).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a read transaction; accepted only while `busy`=0.
- `burst_size`  in  2  bytes per word: 0=1, 1=2, 2=4, 3=8; latched on accepted `start`.
- `burst_num`  in  4  words in the transaction; latched on `start`; 0 is treated as 1.
- `dqs_valid`  in  1  a beat is present on `dq_rise`/`dq_fall` this cycle.
- `dq_rise`  in  8  byte captured on the DQS rising edge (earlier byte).
- `dq_fall`  in  8  byte captured on the DQS falling edge (later byte).
- `pool_rdata`  out  64  assembled word; little-endian, zero-extended above the burst size.
- `rdata_valid`  out  1  one-cycle pulse: `pool_rdata` holds a complete word.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse with the last word's `rdata_valid`.
- `timeout_err`  out  1  one-cycle pulse on abort (only when the timeout feature is compiled in; tied 0 otherwise).

## Operation
- States: IDLE, COLLECT. In IDLE, `start` latches `burst_size` and `burst_num`, clears the beat counter, word counter and shift register, then moves to COLLECT.
- Beats per word: size 0 → 1 beat, `dq_rise` only, `dq_fall` ignored. Size 1 → 1 beat. Size 2 → 2 beats. Size 3 → 4 beats.
- Byte placement: beat k places `dq_rise` at byte 2k and `dq_fall` at byte 2k+1. Unused upper bytes are 0.
- Each cycle in COLLECT with `dqs_valid`=1 consumes one beat. When `dqs_valid`=0 the block stalls and holds its partial word with no penalty.
- Final beat of a word: the word is registered to `pool_rdata` and `rdata_valid` pulses. The beat counter clears and the word counter increments.
- Final beat of the final word: additionally `done` pulses and the state returns to IDLE.
- `dqs_valid` in IDLE, and in the cycle `start` is accepted, is ignored.
- `start` while `busy`=1 is ignored. The latched size and count cannot change mid-transaction.
- Reset mid-operation: the partial word is discarded, no `rdata_valid` or `done` pulse is produced, and the state goes to IDLE.

## Timing
- Reset values: `pool_rdata`=0, `rdata_valid`=0, `busy`=0, `done`=0, `timeout_err`=0.
- `busy` rises the cycle after `start` is accepted.
- Latency: `rdata_valid` asserts in the cycle after the final beat of a word is sampled.
- `pool_rdata` holds its value until the next word completes.
- `busy` falls in the same cycle `done` asserts, so a new `start` is accepted that cycle.
- Back-to-back words: with `dqs_valid` held high, sizes 0/1 yield one word per cycle, size 2 one word per 2 cycles, and size 3 one word per 4 cycles.

## Configuration
- `BYTE_TO_BURST_TIMEOUT_EN` defined:
  - A counter runs in COLLECT, counts consecutive cycles with `dqs_valid`=0, and clears on any beat.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_err` pulses for one cycle and the state returns to IDLE.
  - The partial word is discarded, no `done` pulse is produced, and `busy` falls that cycle.
- Not defined: no counter is built, `timeout_err` is tied 0, and the block waits indefinitely for strobes.

## Structure
- Shared DDR package holds:
  - `burst_size_t` enum (BURST_1B, BURST_2B, BURST_4B, BURST_8B), shared with the write serializer.
  - The read FSM state enum.
  - A `beats_for_size` function.
  - `MAX_BURST_NUM`=15.
- One sub-module, `rx_word_assembler`: beat-indexed byte-lane register with clear and load-complete outputs. The FSM, counters and timeout logic stay in the top module.

## Test plan
- Reset: hold `rst` for 2 cycles → all outputs 0; `dqs_valid` pulses in IDLE produce no output.
- Single 8-byte word: `start`, size 3, num 1, then beats (rise,fall) = (6b,07), (89,de), (a4,74), (a8,44) on consecutive cycles → `pool_rdata`=64'h44a874a4de89076b with `rdata_valid` and `done` one cycle after the 4th beat.
- Size 0, num 2: beats rise=30/fall=ff, then rise=3a/fall=ff → words 64'h30 and 64'h3a on consecutive cycles; fall bytes ignored; `done` with the second word.
- Size 2 with a strobe gap: beats (5d,1e), 2 idle cycles, (a0,0a) → 64'h0aa01e5d two cycles later than the gap-free case; no spurious `rdata_valid`.
- Reset mid-burst: size 3, num 2, `rst` after 2 beats → no `rdata_valid`; a fresh transaction afterwards assembles correctly.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): size 1, num 3, one word delivered, then strobe idle for 16 cycles → `timeout_err` pulse, `busy` falls, no `done`.
